score_display_ctrl: RTL
=======================

// Module: score_display_ctrl
// PURPOSE
// - Upstream feeder for the per-digit score glyph ROMs: keeps the running game score as a saturating BCD counter.
// - Snapshots the score once per frame, then drives each glyph ROM with its digit value plus h_enable/v_enable windows derived from the VGA beam position.
// - ORs the returned glyph pixels into a single score_pixel for the colour mixer.
// PARAMETERS
// NUM_DIGITS  4    number of decimal digits; one glyph ROM instance per digit
// X0          16   hcount of left edge of leftmost (most significant) digit
// Y0          8    vcount of top row of digits
// DIGIT_W     16   glyph width in pixels; matches ROM row width
// DIGIT_H     16   glyph height in lines; matches ROM row count
// GAP         4    blank pixels between adjacent digits
// PORTS
// clk          in   1             pixel clock
// reset        in   1             asynchronous, active-high
// game_clear   in   1             sync pulse: score <= 0 (new game)
// add_1        in   1             sync pulse: score += 1 (pellet)
// add_10       in   1             sync pulse: score += 10 (power pellet / ghost)
// hcount       in   10            current beam column from VGA timing
// vcount       in   10            current beam line from VGA timing
// pixel_in     in   NUM_DIGITS    glyph pixel from each digit ROM; bit i = digit i
// score_val    out  4*NUM_DIGITS  digit values to ROMs; nibble i = digit i (nibble 0 = units)
// h_enable     out  NUM_DIGITS    per-digit horizontal window, to ROM i
// v_enable     out  1             shared vertical window, to all ROMs
// score_pixel  out  1             OR of pixel_in bits gated by display window
// score_bcd    out  4*NUM_DIGITS  live (un-snapshotted) score for game logic
// saturated    out  1             high while score == all nines
// BEHAVIOUR
// - Reset: score_bcd, score_val and snapshot = 0; h_enable = 0, v_enable = 0, score_pixel = 0, saturated = 0.
// - Score counter, evaluated each clk:
//   - game_clear has priority: score = 0, add pulses ignored that cycle.
//   - Otherwise the increment is 1*add_1 + 10*add_10; both high = +11 in one cycle.
//   - BCD add with per-nibble decimal carry: 0099 + 1 = 0100, 0999 + 10 = 1009.
//   - Saturating: any add whose result would exceed all nines yields all nines (9999 for 4 digits).
//   - saturated is registered; it is high in the cycle after score reaches all nines.
//   - Increments apply with 1-cycle latency to score_bcd.
// - Snapshot: score_val <= score_bcd when hcount==0 && vcount==0.
//   - Display never tears mid-frame.
//   - An add in the snapshot cycle appears the following frame.
// - Windows: registered, 1 cycle after hcount/vcount.
//   - v_enable = (Y0 <= vcount < Y0+DIGIT_H).
//   - Digit i left edge Xi = X0 + (NUM_DIGITS-1-i)*(DIGIT_W+GAP), so units is the rightmost digit.
//   - h_enable[i] = v_window && (Xi <= hcount < Xi+DIGIT_W).
//   - h_enable windows are mutually exclusive.
// - ROM contract:
//   - Each h_enable[i] run is exactly DIGIT_W cycles per line.
//   - h_enable[i] is low at least 1 cycle per line inside the v window; this advances the ROM row counter.
//   - v_enable drops at least once per frame; this rewinds the ROMs.
// - score_pixel = |(pixel_in & win_d); registered.
//   - win_d is h_enable delayed 1 cycle to match the ROM registered output.
//   - Total beam-to-score_pixel latency: 3 cycles (window reg + ROM + output reg).
// - Leading zeros are displayed; no blanking.
// - Reset mid-frame: all outputs drop immediately (async). Windows resume on the next qualifying hcount/vcount; the score restarts at 0.
// - Arithmetic is in BCD only. Illegal nibbles (A-F) cannot arise from reset/add/clear and need no handling.
// TESTING
// - reset, then 12 add_1 pulses -> score_bcd = 0x0012; score_val still 0x0000 until the hcount=0,vcount=0 cycle, then 0x0012.
// - score 0x0099, add_1 -> 0x0100; score 0x0995, add_10 and add_1 same cycle -> 0x1006.
// - score 0x9995, add_10 -> 0x9999, saturated=1 next cycle; further add_1 -> stays 0x9999.
// - add_10 and game_clear same cycle from 0x0500 -> 0x0000, saturated=0.
// - sweep a full frame with defaults:
//   - v_enable high for lines 8..23 only.
//   - h_enable[3] high for hcount 16..31, [2] 36..51, [1] 56..71, [0] 76..91.
//   - Each run is 16 cycles; never two bits high at once.
// - ROMs driven with pixel_in = h_enable delayed 1 -> score_pixel high exactly 3 cycles after each in-window beam position.
// - Assert reset mid-frame at vcount=12 -> all outputs 0 same cycle; next frame windows are correct and score_val = 0x0000.

Source files
------------

// File: rtl/score_display_ctrl.sv
`timescale 1ns/1ps
// score_display_ctrl
// Keeps the running game score as a saturating BCD counter, snapshots it once
// per frame for the glyph ROMs, generates the per-digit beam windows and
// merges the returned glyph pixels into one score pixel.
module score_display_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int X0         = 16,
    parameter int Y0         = 8,
    parameter int DIGIT_W    = 16,
    parameter int DIGIT_H    = 16,
    parameter int GAP        = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    game_clear,
    input  logic                    add_1,
    input  logic                    add_10,
    input  logic [9:0]              hcount,
    input  logic [9:0]              vcount,
    input  logic [NUM_DIGITS-1:0]   pixel_in,
    output logic [4*NUM_DIGITS-1:0] score_val,
    output logic [NUM_DIGITS-1:0]   h_enable,
    output logic                    v_enable,
    output logic                    score_pixel,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic                    saturated
);

    localparam int              SW    = 4 * NUM_DIGITS;
    localparam logic [SW-1:0]   NINES = {NUM_DIGITS{4'h9}};

    // Decimal add of add_1 into the units nibble and add_10 into the tens
    // nibble, rippling a decimal carry upward. A carry out of the top digit
    // means the true sum exceeds all nines, so the result clamps there.
    function automatic logic [SW-1:0] bcd_add(input logic [SW-1:0] s,
                                              input logic          a1,
                                              input logic          a10);
        logic [SW-1:0] r;
        logic [4:0]    d;
        logic          c;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = {1'b0, s[4*i +: 4]} + {4'b0, c};
            if (i == 0) d = d + {4'b0, a1};
            if (i == 1) d = d + {4'b0, a10};
            if (d >= 5'd10) begin
                d = d - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i +: 4] = d[3:0];
        end
        // A single-digit score has no tens nibble: any +10 overflows it.
        if (c || (NUM_DIGITS == 1 && a10)) r = NINES;
        return r;
    endfunction

    logic [SW-1:0]         r_score;
    logic [SW-1:0]         r_snap;
    logic                  r_sat;
    logic [NUM_DIGITS-1:0] r_h_en;
    logic                  r_v_en;
    logic [NUM_DIGITS-1:0] r_win_d;
    logic                  r_pix;

    logic [SW-1:0]         w_score_nxt;
    logic [31:0]           w_hc;
    logic [31:0]           w_vc;
    logic                  w_v_win;
    logic [NUM_DIGITS-1:0] w_h_win;

    assign w_score_nxt = bcd_add(r_score, add_1, add_10);
    assign w_hc        = {22'd0, hcount};
    assign w_vc        = {22'd0, vcount};

    // Beam windows: shared vertical band, one horizontal slot per digit with
    // the units digit rightmost. Slots are separated by GAP so they never overlap.
    always_comb begin
        int xi;
        xi      = 0;
        w_v_win = (w_vc >= 32'(Y0)) && (w_vc < 32'(Y0 + DIGIT_H));
        w_h_win = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            xi = X0 + (NUM_DIGITS - 1 - i) * (DIGIT_W + GAP);
            if (w_v_win && (w_hc >= 32'(xi)) && (w_hc < 32'(xi + DIGIT_W)))
                w_h_win[i] = 1'b1;
        end
    end

    // Live score: a new game clears it and overrides any add in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_score <= '0;
        else if (game_clear)
            r_score <= '0;
        else
            r_score <= w_score_nxt;
    end

    // Saturation flag trails the live score by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_sat <= 1'b0;
        else
            r_sat <= (r_score == NINES);
    end

    // Frame snapshot at the first beam position so a frame never shows two scores.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_snap <= '0;
        else if (hcount == 10'd0 && vcount == 10'd0)
            r_snap <= r_score;
    end

    // Registered ROM windows, one cycle behind the beam position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v_en <= 1'b0;
            r_h_en <= '0;
        end else begin
            r_v_en <= w_v_win;
            r_h_en <= w_h_win;
        end
    end

    // Delay the windows to line up with the ROMs' registered pixels, then merge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_d <= '0;
            r_pix   <= 1'b0;
        end else begin
            r_win_d <= r_h_en;
            r_pix   <= |(pixel_in & r_win_d);
        end
    end

    assign score_bcd   = r_score;
    assign saturated   = r_sat;
    assign score_val   = r_snap;
    assign v_enable    = r_v_en;
    assign h_enable    = r_h_en;
    assign score_pixel = r_pix;

endmodule
